led_trail_fader: RTL

- Downstream stage of the LED rotator.
- Consumes the 8-bit one-hot rotating pattern and drives the board LEDs.
- Per-LED PWM brightness gives a fading "comet trail": newly lit LEDs jump to full brightness, released LEDs decay linearly to off.
- Sits between the rotator's led_state and the LEDR pins.

---
 rtl/led_trail_fader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/led_trail_fader.sv
// -----------------------------------------------------------------------------
// led_trail_fader
//
// Downstream stage of the LED rotator. Takes the rotator's one-hot pattern and
// drives the board LEDs with per-channel PWM so that the lit LED leaves a
// fading "comet trail": a newly lit LED jumps to full brightness, and an LED
// that is released decays linearly to off.
//
// Ports:
//   CLOCK_50       in   1         system clock (50 MHz)
//   RESET_N        in   1         synchronous active-low reset
//   pattern_in     in   NUM_LEDS  LED pattern from the rotator
//   pattern_valid  in   1         one-cycle strobe, pattern_in sampled when high
//   enable         in   1         output enable, low blanks all LEDs
//   LEDR           out  NUM_LEDS  PWM-modulated LED drive (registered)
//   frame_tick     out  1         one-cycle pulse after the PWM terminal count
//
// Build option:
//   LED_TRAIL_GAMMA_EN  when defined, the PWM compare uses a gamma-corrected
//                       duty (shadow*shadow >> PWM_BITS) instead of the linear
//                       shadow value. Default build is linear.
// -----------------------------------------------------------------------------
module led_trail_fader #(
    parameter int NUM_LEDS   = 8,
    parameter int PWM_BITS   = 8,
    parameter int DECAY_DIV  = 250000,
    parameter int DECAY_STEP = 8
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [NUM_LEDS-1:0] pattern_in,
    input  logic                pattern_valid,
    input  logic                enable,
    output logic [NUM_LEDS-1:0] LEDR,
    output logic                frame_tick
);

    localparam int                  DIV_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PWM_BITS-1:0] BMAX     = '1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DECAY_DIV - 1);
    localparam logic [PWM_BITS:0]   STEP_EXT = (PWM_BITS + 1)'(DECAY_STEP);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DIV_W-1:0]    decay_cnt;
    logic [NUM_LEDS-1:0] cur_pattern;
    logic [PWM_BITS-1:0] bright     [NUM_LEDS];
    logic [PWM_BITS-1:0] shadow     [NUM_LEDS];
    logic [PWM_BITS-1:0] bright_nxt [NUM_LEDS];
    logic [PWM_BITS:0]   dec_ext    [NUM_LEDS];
    logic [PWM_BITS-1:0] duty       [NUM_LEDS];
    logic [NUM_LEDS-1:0] eff_pattern;
    logic                decay_tick;
    logic                frame_end;

    assign frame_end  = (pwm_cnt == BMAX);
    assign decay_tick = (decay_cnt == DIV_LAST);

    // Next brightness per channel. A fresh load wins, a lit channel holds full
    // scale, otherwise the channel decays on a decay tick. The decrement is
    // done one bit wider so a borrow shows up in the top bit and clamps to 0
    // instead of wrapping back to full brightness.
    always_comb begin
        // NOTE: every combinational output is assigned on all paths (here
        // unconditionally first), otherwise synthesis infers a latch.
        eff_pattern = pattern_valid ? pattern_in : cur_pattern;
        for (int i = 0; i < NUM_LEDS; i++) begin
            dec_ext[i] = {1'b0, bright[i]} - STEP_EXT;
            if (pattern_valid && pattern_in[i]) begin
                bright_nxt[i] = BMAX;
            end else if (eff_pattern[i]) begin
                bright_nxt[i] = BMAX;
            end else if (decay_tick) begin
                bright_nxt[i] = dec_ext[i][PWM_BITS] ? '0 : dec_ext[i][PWM_BITS-1:0];
            end else begin
                bright_nxt[i] = bright[i];
            end
        end
    end

`ifdef LED_TRAIL_GAMMA_EN
    // Gamma-corrected duty, squared at double width and registered on the same
    // edge that loads the shadow, so the compare latency is unchanged.
    logic [PWM_BITS-1:0]   gamma_duty [NUM_LEDS];
    logic [2*PWM_BITS-1:0] bright_sq  [NUM_LEDS];

    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            bright_sq[i] = (2*PWM_BITS)'(bright[i]) * (2*PWM_BITS)'(bright[i]);
            duty[i]      = gamma_duty[i];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                gamma_duty[i] <= '0;
            end
        end else if (frame_end) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                gamma_duty[i] <= bright_sq[i][2*PWM_BITS-1:PWM_BITS];
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            duty[i] = shadow[i];
        end
    end
`endif

    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!RESET_N) begin
            pwm_cnt     <= '0;
            decay_cnt   <= '0;
            cur_pattern <= '0;
            frame_tick  <= 1'b0;
            LEDR        <= '0;
            // NOTE: the brightness and shadow arrays are reset explicitly so a
            // reset in the middle of a fade leaves no tail on the LEDs.
            for (int i = 0; i < NUM_LEDS; i++) begin
                bright[i] <= '0;
                shadow[i] <= '0;
            end
        end else begin
            pwm_cnt    <= pwm_cnt + 1'b1;
            decay_cnt  <= decay_tick ? '0 : decay_cnt + 1'b1;
            frame_tick <= frame_end;
            if (pattern_valid) begin
                cur_pattern <= pattern_in;
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                bright[i] <= bright_nxt[i];
                // Duty only changes at the frame boundary, so a frame never
                // mixes two brightness levels.
                if (frame_end) begin
                    shadow[i] <= bright[i];
                end
                LEDR[i] <= enable && (pwm_cnt < duty[i]);
            end
        end
    end

endmodule
